cmp_sort_ctrl: RTL and testbench
================================

# cmp_sort_ctrl

Sequencer that owns one 4-bit magnitude comparator and uses it to sort a small burst of 4-bit values in place. It accepts up to DEPTH values over a valid/ready input stream, runs a bubble sort issuing exactly one comparison per clock, then streams the sorted values out over a valid/ready output stream. It sits between a 4-bit data source and any consumer that needs ordered data, such as min/max selection or a median filter.

## Interface
- DEPTH, 8, maximum values per burst; range 2..16.
- DESCEND, 0, 0 = ascending output order, 1 = descending.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- in_valid  in  1  input beat valid.
- in_data  in  4  input value, unsigned.
- in_last  in  1  marks the final beat of a burst.
- in_ready  out  1  high only in LOAD.
- out_valid  out  1  high only in DRAIN.
- out_data  out  4  sorted value at the read pointer.
- out_last  out  1  high with the final output beat.
- busy  out  1  high in SORT or DRAIN.
- sorted  out  1  one-cycle pulse on the SORT→DRAIN (or LOAD→DRAIN) transition.

## Operation
- States: LOAD, SORT, DRAIN. Reset state is LOAD.
- LOAD:
  - On in_valid & in_ready, write in_data to mem[wr_ptr] and increment wr_ptr.
  - Burst ends on an accepted beat with in_last=1, or on the DEPTH-th accepted beat (implied last).
  - At burst end, store count N = beats accepted (1..DEPTH).
  - If N=1, go to DRAIN. Otherwise go to SORT with idx=0, pass=0, swapped=0.
- SORT:
  - Each cycle, compare A=mem[idx] and B=mem[idx+1] using the comparator.
  - Swap condition: A_gret (DESCEND=0) or A_lt (DESCEND=1). Equal values never swap, so the sort is stable.
  - On a swap, write both entries at the clock edge and set swapped.
  - After idx = N-2, the pass is complete:
    - If swapped=0, or pass = N-2 (N-1 passes done), go to DRAIN.
    - Otherwise increment pass, clear swapped, set idx=0.
- DRAIN:
  - out_data = mem[rd_ptr], unregistered from the memory.
  - On out_valid & out_ready, increment rd_ptr.
  - out_last = (rd_ptr = N-1).
  - Once the last beat is accepted, clear pointers and go to LOAD.
- Widths:
  - Pointers and idx are clog2(DEPTH) bits. N is clog2(DEPTH)+1 bits.
  - All comparisons are unsigned 4-bit.
- Reset values (all outputs and state):
  - in_ready=1, out_valid=0, out_data=0, out_last=0, busy=0, sorted=0.
  - mem, pointers, N, pass, idx, and swapped are all cleared.
  - Reset asserted mid-SORT or mid-DRAIN discards the burst immediately.

## Timing
- in_ready falls in the cycle after the last beat is accepted.
- SORT time:
  - Already-ordered burst: N-1 cycles.
  - Worst case: (N-1)² cycles.
  - No idle cycles between passes.
- out_valid rises the cycle after the final SORT compare. sorted pulses in that same cycle.
- in_valid is ignored outside LOAD. out_ready is ignored outside DRAIN.
- out_data is held stable while out_valid=1 and out_ready=0.
- Back-to-back bursts: in_ready rises the cycle after the final output handshake.

## Structure
- Shared package cmp_pkg:
  - state enum {LOAD, SORT, DRAIN}.
  - Constant CMP_W = 4.
  - Default DEPTH.
- Sub-module mag_compare4:
  - Purely combinational.
  - Inputs: A[3:0], B[3:0]. Outputs: A_gret, A_lt, A_eq.
  - Exactly one output high for every input pair.
  - Instantiated once. It is the only magnitude compare in the block.
- Top level contains the FSM, register-file memory, and pointer/pass counters.

## Test plan
- Reverse burst, DEPTH=8, ascending: 7,6,5,4,3,2,1,0 with last on beat 8.
  - Output 0..7 with out_last on 7.
  - SORT lasts 49 cycles; sorted pulses once.
- Pre-sorted burst: 1,2,3,9.
  - SORT lasts exactly 3 cycles; output 1,2,3,9.
- Duplicates, DESCEND=1: 5,F,5,0,F.
  - Output F,F,5,5,0.
  - No swap on equal pairs; per-pass swap flags checked.
- N=1 burst: value A with in_last.
  - Output A after LOAD→DRAIN with no SORT cycles; sorted still pulses.
- Backpressure: out_ready toggles 1,0,0,1 during DRAIN.
  - out_data is stable while stalled; no beat is dropped or duplicated.
  - in_valid asserted during DRAIN is not accepted.
- Reset: rst_n pulsed low mid-SORT (pass 2).
  - All outputs return to reset values asynchronously; in_ready=1.
  - A fresh burst of 3,1,2 then outputs 1,2,3.

Source files
------------

// File: rtl/cmp_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cmp_pkg : shared types and constants for the compare-and-sort sequencer
// Revision 1.0
// ---------------------------------------------------------------------------
package cmp_pkg;

  localparam int CMP_W         = 4;
  localparam int DEFAULT_DEPTH = 8;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    SORT  = 2'd1,
    DRAIN = 2'd2
  } state_e;

endpackage
`default_nettype wire

// File: rtl/mag_compare4.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mag_compare4 : combinational unsigned 4-bit magnitude comparator
// Revision 1.0
// ---------------------------------------------------------------------------
module mag_compare4
  import cmp_pkg::*;
(
  input  logic [CMP_W-1:0] A,
  input  logic [CMP_W-1:0] B,
  output logic             A_gret,
  output logic             A_lt,
  output logic             A_eq
);

  always_comb begin
    A_gret = (A > B);
    A_lt   = (A < B);
    A_eq   = (A == B);
  end

endmodule
`default_nettype wire

// File: rtl/cmp_sort_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cmp_sort_ctrl : loads a burst of 4-bit values, bubble-sorts it in place with
//                 one compare per clock, then streams the sorted burst out
// Revision 1.0
// ---------------------------------------------------------------------------
module cmp_sort_ctrl
  import cmp_pkg::*;
#(
  parameter int DEPTH   = DEFAULT_DEPTH,
  parameter bit DESCEND = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [CMP_W-1:0] in_data,
  input  logic             in_last,
  output logic             in_ready,
  output logic             out_valid,
  output logic [CMP_W-1:0] out_data,
  output logic             out_last,
  input  logic             out_ready,
  output logic             busy,
  output logic             sorted
);

  localparam int            PW        = $clog2(DEPTH);
  localparam int            NW        = PW + 1;
  localparam logic [PW-1:0] LAST_SLOT = PW'(DEPTH - 1);

  state_e           state_q, state_d;
  logic [CMP_W-1:0] mem_q [DEPTH];
  logic [CMP_W-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]    idx_q, idx_d;
  logic [PW-1:0]    pass_q, pass_d;
  logic [NW-1:0]    n_q, n_d;
  logic             swapped_q, swapped_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic             busy_q, busy_d;
  logic             sorted_q, sorted_d;

  logic [PW-1:0]    idx_nxt;
  logic [CMP_W-1:0] cmp_a, cmp_b;
  logic             cmp_gret, cmp_lt, cmp_eq;
  logic             do_swap, swap_any;
  logic             last_idx, last_pass, rd_last;

  assign idx_nxt = idx_q + 1'b1;
  assign cmp_a   = mem_q[idx_q];
  assign cmp_b   = mem_q[idx_nxt];

  mag_compare4 u_cmp (
    .A      (cmp_a),
    .B      (cmp_b),
    .A_gret (cmp_gret),
    .A_lt   (cmp_lt),
    .A_eq   (cmp_eq)
  );

  // Equal pairs are excluded explicitly so the sort stays stable
  assign do_swap   = !cmp_eq && (DESCEND ? cmp_lt : cmp_gret);
  assign swap_any  = swapped_q | do_swap;
  assign last_idx  = ({1'b0, idx_q}    == (n_q - NW'(2)));
  assign last_pass = ({1'b0, pass_q}   == (n_q - NW'(2)));
  assign rd_last   = ({1'b0, rd_ptr_q} == (n_q - NW'(1)));

  always_comb begin
    state_d     = state_q;
    mem_d       = mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    idx_d       = idx_q;
    pass_d      = pass_q;
    n_d         = n_q;
    swapped_d   = swapped_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;
    sorted_d    = 1'b0;

    case (state_q)
      LOAD: begin
        if (in_valid && in_ready_q) begin
          mem_d[wr_ptr_q] = in_data;
          wr_ptr_d        = wr_ptr_q + 1'b1;
          if (in_last || (wr_ptr_q == LAST_SLOT)) begin
            wr_ptr_d   = '0;
            n_d        = NW'(wr_ptr_q) + NW'(1);
            idx_d      = '0;
            pass_d     = '0;
            swapped_d  = 1'b0;
            in_ready_d = 1'b0;
            busy_d     = 1'b1;
            if (wr_ptr_q == '0) begin
              state_d     = DRAIN;
              out_valid_d = 1'b1;
              sorted_d    = 1'b1;
            end else begin
              state_d = SORT;
            end
          end
        end
      end

      SORT: begin
        if (do_swap) begin
          mem_d[idx_q]   = cmp_b;
          mem_d[idx_nxt] = cmp_a;
        end
        if (last_idx) begin
          idx_d     = '0;
          swapped_d = 1'b0;
          if (!swap_any || last_pass) begin
            pass_d      = '0;
            state_d     = DRAIN;
            out_valid_d = 1'b1;
            sorted_d    = 1'b1;
          end else begin
            pass_d = pass_q + 1'b1;
          end
        end else begin
          idx_d     = idx_nxt;
          swapped_d = swap_any;
        end
      end

      DRAIN: begin
        if (out_valid_q && out_ready) begin
          if (rd_last) begin
            rd_ptr_d    = '0;
            state_d     = LOAD;
            in_ready_d  = 1'b1;
            out_valid_d = 1'b0;
            busy_d      = 1'b0;
          end else begin
            rd_ptr_d = rd_ptr_q + 1'b1;
          end
        end
      end

      default: begin
        state_d     = LOAD;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
        busy_d      = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= LOAD;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      idx_q       <= '0;
      pass_q      <= '0;
      n_q         <= '0;
      swapped_q   <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      sorted_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      idx_q       <= idx_d;
      pass_q      <= pass_d;
      n_q         <= n_d;
      swapped_q   <= swapped_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      sorted_q    <= sorted_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = mem_q[rd_ptr_q];
  assign out_last  = out_valid_q && rd_last;
  assign busy      = busy_q;
  assign sorted    = sorted_q;

endmodule
`default_nettype wire

// File: tb/tb_cmp_sort_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_cmp_sort_ctrl : ascending and descending instances fed the same bursts
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_cmp_sort_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, in_last;
  logic [3:0] in_data;
  logic       rdy_a, rdy_d;

  logic       a_in_ready, a_out_valid, a_out_last, a_busy, a_sorted;
  logic [3:0] a_out_data;
  logic       d_in_ready, d_out_valid, d_out_last, d_busy, d_sorted;
  logic [3:0] d_out_data;

  always #5 clk = ~clk;

  cmp_sort_ctrl #(.DEPTH(8), .DESCEND(1'b0)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(a_in_ready),
    .out_valid(a_out_valid), .out_data(a_out_data), .out_last(a_out_last),
    .out_ready(rdy_a), .busy(a_busy), .sorted(a_sorted)
  );

  cmp_sort_ctrl #(.DEPTH(8), .DESCEND(1'b1)) dut_d (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(d_in_ready),
    .out_valid(d_out_valid), .out_data(d_out_data), .out_last(d_out_last),
    .out_ready(rdy_d), .busy(d_busy), .sorted(d_sorted)
  );

  int checks   = 0;
  int failures = 0;

  int sort_cyc_a = 0, sort_cyc_d = 0, pulse_a = 0, pulse_d = 0;

  // SORT is the only state with busy high and out_valid low
  always @(negedge clk) begin
    if (a_busy && !a_out_valid) sort_cyc_a++;
    if (d_busy && !d_out_valid) sort_cyc_d++;
    if (a_sorted) pulse_a++;
    if (d_sorted) pulse_d++;
  end

  logic [3:0] stim[$];
  logic [3:0] exp_a[$];
  logic [3:0] exp_d[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic send(input bit use_last);
    logic [3:0] s[$];
    logic [3:0] t;
    foreach (stim[i]) begin
      @(negedge clk);
      chk("load_ready", 32'({a_in_ready, d_in_ready}), 3);
      in_valid = 1'b1;
      in_data  = stim[i];
      in_last  = use_last && (i == stim.size() - 1);
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    chk("ready_fall", 32'({a_in_ready, d_in_ready}), 0);
    s = stim;
    for (int i = 1; i < s.size(); i++)
      for (int j = i; j > 0 && s[j-1] > s[j]; j--) begin
        t = s[j]; s[j] = s[j-1]; s[j-1] = t;
      end
    foreach (s[i]) exp_a.push_back(s[i]);
    for (int i = s.size() - 1; i >= 0; i--) exp_d.push_back(s[i]);
  endtask

  task automatic drain(input bit dsel, input bit stall, input bit poke);
    int         cyc = 0, k = 0, left;
    bit         done = 0, stalled = 0, r;
    logic [3:0] held = 4'h0, e, od;
    logic       ov, ol, ir;
    while (!done && cyc < 400) begin
      @(negedge clk);
      cyc++;
      ov = dsel ? d_out_valid : a_out_valid;
      ol = dsel ? d_out_last  : a_out_last;
      od = dsel ? d_out_data  : a_out_data;
      ir = dsel ? d_in_ready  : a_in_ready;
      if (poke) begin
        in_valid = 1'b1;
        in_data  = 4'hF;
        if (ov) chk("drain_in_ready", 32'(ir), 0);
      end
      r = 1'b0;
      if (ov) begin
        r = stall ? ((k % 4 == 0) || (k % 4 == 3)) : 1'b1;
        k++;
        if (stalled) chk("stall_hold", 32'(od), 32'(held));
        left = dsel ? exp_d.size() : exp_a.size();
        if (left == 0) begin
          chk("extra_beat", 32'(ov), 0);
          done = 1;
        end else if (r) begin
          e = dsel ? exp_d.pop_front() : exp_a.pop_front();
          chk(dsel ? "out_data_d" : "out_data_a", 32'(od), 32'(e));
          chk(dsel ? "out_last_d" : "out_last_a", 32'(ol), 32'(left == 1));
          done    = (left == 1);
          stalled = 0;
        end else begin
          stalled = 1;
          held    = od;
        end
      end
      if (dsel) rdy_d = r; else rdy_a = r;
    end
    chk("drain_done", 32'(done), 1);
    @(negedge clk);
    rdy_a    = 1'b0;
    rdy_d    = 1'b0;
    in_valid = 1'b0;
  endtask

  task automatic burst(input bit use_last, input bit stall, input bit poke,
                       input int ecyc_a, input int ecyc_d);
    int sa = sort_cyc_a, sd = sort_cyc_d, pa = pulse_a, pd = pulse_d;
    send(use_last);
    drain(1'b0, stall, poke);
    drain(1'b1, stall, 1'b0);
    if (ecyc_a >= 0) chk("sort_cycles_a", 32'(sort_cyc_a - sa), 32'(ecyc_a));
    if (ecyc_d >= 0) chk("sort_cycles_d", 32'(sort_cyc_d - sd), 32'(ecyc_d));
    chk("sorted_pulse_a", 32'(pulse_a - pa), 1);
    chk("sorted_pulse_d", 32'(pulse_d - pd), 1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_in_ready"},  32'({a_in_ready, d_in_ready}), 3);
    chk({tag, "_out_valid"}, 32'({a_out_valid, d_out_valid}), 0);
    chk({tag, "_out_last"},  32'({a_out_last, d_out_last}), 0);
    chk({tag, "_busy"},      32'({a_busy, d_busy}), 0);
    chk({tag, "_sorted"},    32'({a_sorted, d_sorted}), 0);
    chk({tag, "_out_data"},  32'({a_out_data, d_out_data}), 0);
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = 4'h0;
    rdy_a    = 1'b0;
    rdy_d    = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset_outputs("rst");
    rst_n = 1'b1;

    stim = '{4'h7, 4'h6, 4'h5, 4'h4, 4'h3, 4'h2, 4'h1, 4'h0};
    burst(1'b1, 1'b0, 1'b0, 49, 7);

    stim = '{4'h1, 4'h2, 4'h3, 4'h9};
    burst(1'b1, 1'b0, 1'b0, 3, 9);

    stim = '{4'h5, 4'hF, 4'h5, 4'h0, 4'hF};
    burst(1'b1, 1'b0, 1'b0, 16, 16);

    stim = '{4'hA};
    burst(1'b1, 1'b0, 1'b0, 0, 0);

    stim = '{4'h2, 4'h8, 4'h2, 4'h6};
    burst(1'b1, 1'b1, 1'b1, -1, -1);

    // full-depth burst with no in_last: the eighth beat closes it
    stim = '{4'hC, 4'h3, 4'hE, 4'h1, 4'h9, 4'h0, 4'h7, 4'h5};
    burst(1'b0, 1'b0, 1'b0, -1, -1);

    stim = '{4'h7, 4'h6, 4'h5, 4'h4, 4'h3, 4'h2, 4'h1, 4'h0};
    send(1'b1);
    repeat (17) @(negedge clk);
    chk("pre_reset_a_sorting", 32'(a_busy && !a_out_valid), 1);
    chk("pre_reset_d_draining", 32'(d_out_valid), 1);
    #2 rst_n = 1'b0;
    #1 chk_reset_outputs("arst");
    exp_a.delete();
    exp_d.delete();
    @(negedge clk);
    rst_n = 1'b1;

    stim = '{4'h3, 4'h1, 4'h2};
    burst(1'b1, 1'b0, 1'b0, 4, 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
